// File: rtl/axil_arb_pkg.sv
// Shared types and helpers for the AXI-Lite arbiters.
// Holds the arbiter FSM encoding and arbitration mode constants.
package axil_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ADDR_DATA = 2'd1,
      RESP      = 2'd2
   } arb_state_e;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axil_arb_pick.sv
// Combinational winner picker: rotate by start pointer, then
// priority-encode the lowest set bit and map back to an index.
module axil_arb_pick
   import axil_arb_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = idx_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             rr_mode,
   output logic [N-1:0]     winner,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   localparam logic [IDX_W:0] NV = (IDX_W+1)'(N);

   logic [N-1:0]     rot;
   logic [IDX_W-1:0] start;
   logic [IDX_W-1:0] off;
   logic [IDX_W:0]   sum;

   always_comb begin
      start = rr_mode ? ptr : '0;
      // Doubling the vector makes the rotate a plain shift.
      rot   = N'({req, req} >> start);
      off   = '0;
      any   = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = IDX_W'(i);
            any = 1'b1;
         end
      end
      sum = {1'b0, start} + {1'b0, off};
      if (sum >= NV) begin
         sum = sum - NV;
      end
      idx    = sum[IDX_W-1:0];
      winner = any ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/axil_arbiter_wr.sv
// AXI-Lite write-channel arbiter: holds one grant across the
// AW, W and B handshakes, then hands over with no idle cycle.
module axil_arbiter_wr
   import axil_arb_pkg::*;
#(
   parameter  int NUMBER_MASTER = 2,
   parameter  int ARB_MODE      = 1,
   localparam int IDX_W         = idx_w(NUMBER_MASTER)
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [NUMBER_MASTER-1:0] request_wr,
   output logic [NUMBER_MASTER-1:0] grant_wr,
   output logic [IDX_W-1:0]         grant_wr_idx,
   output logic                     grant_valid,
   input  logic                     mux_awvalid,
   input  logic                     mux_awready,
   input  logic                     mux_wvalid,
   input  logic                     mux_wready,
   input  logic                     mux_bvalid,
   input  logic                     mux_bready
);

   localparam logic [IDX_W:0] NV = (IDX_W+1)'(NUMBER_MASTER);
   localparam logic RR_EN = (ARB_MODE == ARB_RR);

   arb_state_e state_q;
   arb_state_e state_d;

   logic [NUMBER_MASTER-1:0] grant_d;
   logic [NUMBER_MASTER-1:0] pick_oh;
   logic [IDX_W-1:0]         idx_d;
   logic [IDX_W-1:0]         pick_idx;
   logic [IDX_W-1:0]         pick_ptr;
   logic [IDX_W-1:0]         rr_ptr;
   logic [IDX_W-1:0]         rr_d;
   logic [IDX_W-1:0]         rr_next;
   logic [IDX_W:0]           inc;
   logic                     pick_any;
   logic                     aw_done;
   logic                     w_done;
   logic                     aw_d;
   logic                     w_d;
   logic                     aw_hs;
   logic                     w_hs;
   logic                     b_hs;

   assign aw_hs = mux_awvalid & mux_awready;
   assign w_hs  = mux_wvalid & mux_wready;
   assign b_hs  = mux_bvalid & mux_bready;

   assign inc     = {1'b0, grant_wr_idx} + (IDX_W+1)'(1);
   assign rr_next = (inc >= NV) ? '0 : inc[IDX_W-1:0];

   // Hand-over arbitrates against the pointer it is about to load.
   assign pick_ptr = (state_q == RESP) ? rr_next : rr_ptr;

   assign grant_valid = |grant_wr;

   axil_arb_pick #(
      .N     (NUMBER_MASTER),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (request_wr),
      .ptr     (pick_ptr),
      .rr_mode (RR_EN),
      .winner  (pick_oh),
      .idx     (pick_idx),
      .any     (pick_any)
   );

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         grant_wr     <= '0;
         grant_wr_idx <= '0;
         aw_done      <= 1'b0;
         w_done       <= 1'b0;
         rr_ptr       <= '0;
      end else begin
         state_q      <= state_d;
         grant_wr     <= grant_d;
         grant_wr_idx <= idx_d;
         aw_done      <= aw_d;
         w_done       <= w_d;
         rr_ptr       <= rr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_wr;
      idx_d   = grant_wr_idx;
      aw_d    = aw_done;
      w_d     = w_done;
      rr_d    = rr_ptr;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick_oh;
               idx_d   = pick_idx;
               state_d = ADDR_DATA;
            end
         end
         ADDR_DATA: begin
            aw_d = aw_done | aw_hs;
            w_d  = w_done | w_hs;
            if (aw_d && w_d) begin
               aw_d    = 1'b0;
               w_d     = 1'b0;
               state_d = RESP;
            end
         end
         RESP: begin
            if (b_hs) begin
               rr_d = rr_next;
               if (pick_any) begin
                  grant_d = pick_oh;
                  idx_d   = pick_idx;
                  state_d = ADDR_DATA;
               end else begin
                  grant_d = '0;
                  idx_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_axil_arbiter_wr.sv
// Bench for axil_arbiter_wr: fixed-priority N=2 and
// round-robin N=4 instances driven from vectors and sequences.
module tb_axil_arbiter_wr;

   logic aclk = 1'b0;
   logic aresetn;
   logic rdy = 1'b1;

   always #5 aclk = ~aclk;

   logic [1:0] r0, g0;
   logic [0:0] i0;
   logic       v0, awv0, wv0, bv0, bb0;

   logic [3:0] r1, g1;
   logic [1:0] i1;
   logic       v1, awv1, wv1, bv1, bb1;

   axil_arbiter_wr #(
      .NUMBER_MASTER (2),
      .ARB_MODE      (0)
   ) u0 (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .request_wr   (r0),
      .grant_wr     (g0),
      .grant_wr_idx (i0),
      .grant_valid  (v0),
      .mux_awvalid  (awv0),
      .mux_awready  (rdy),
      .mux_wvalid   (wv0),
      .mux_wready   (rdy),
      .mux_bvalid   (bv0),
      .mux_bready   (bb0)
   );

   axil_arbiter_wr #(
      .NUMBER_MASTER (4),
      .ARB_MODE      (1)
   ) u1 (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .request_wr   (r1),
      .grant_wr     (g1),
      .grant_wr_idx (i1),
      .grant_valid  (v1),
      .mux_awvalid  (awv1),
      .mux_awready  (rdy),
      .mux_wvalid   (wv1),
      .mux_wready   (rdy),
      .mux_bvalid   (bv1),
      .mux_bready   (bb1)
   );

   typedef struct {
      logic [3:0] req;
      int         exp_idx;
      int         lat;
      int         aw_c;
      int         w_c;
      int         b_st;
      bit         binj;
      bit         idle;
      bit         pulse;
   } vec_t;

   vec_t tbl[10];
   int   exp_q[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int waited, e, last;

      tbl[0] = '{4'b1111, 0, 1, 0, 0, 0, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{4'b1111, 1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{4'b1111, 2, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{4'b1111, 3, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{4'b1111, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{4'b1111, 1, 0, 3, 0, 8, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{4'b0100, 2, 0, 0, 1, 2, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{4'b0101, 0, 0, 0, 0, 1, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{4'b0101, 2, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
      tbl[9] = '{4'b0010, 1, 1, 0, 0, 0, 1'b0, 1'b1, 1'b1};

      aresetn = 1'b0;
      r0 = '0; awv0 = 0; wv0 = 0; bv0 = 0; bb0 = 0;
      r1 = '0; awv1 = 0; wv1 = 0; bv1 = 0; bb1 = 0;
      repeat (3) step();
      chk("rst_g0", g0, 0);
      chk("rst_i0", i0, 0);
      chk("rst_v0", v0, 0);
      chk("rst_g1", g1, 0);
      chk("rst_i1", i1, 0);
      chk("rst_v1", v1, 0);

      // Fixed priority: master 0 keeps winning while it requests.
      aresetn = 1'b1;
      r0 = 2'b11;
      step();
      chk("m0_grant", g0, 1);
      chk("m0_idx", i0, 0);
      chk("m0_valid", v0, 1);
      awv0 = 1; wv0 = 1;
      step();
      awv0 = 0; wv0 = 0;
      step();
      chk("m0_hold", g0, 1);
      bv0 = 1; bb0 = 1;
      step();
      bv0 = 0; bb0 = 0;
      chk("m0_rewin", g0, 1);
      chk("m0_rewin_v", v0, 1);
      awv0 = 1; wv0 = 1;
      step();
      awv0 = 0; wv0 = 0;
      r0 = 2'b10; bv0 = 1; bb0 = 1;
      step();
      bv0 = 0; bb0 = 0;
      chk("m0_m1", g0, 2);
      chk("m0_m1_idx", i0, 1);
      awv0 = 1; wv0 = 1;
      step();
      awv0 = 0; wv0 = 0;
      r0 = 2'b00; bv0 = 1; bb0 = 1;
      step();
      bv0 = 0; bb0 = 0;
      chk("m0_idle", v0, 0);
      chk("m0_idle_g", g0, 0);

      for (int i = 0; i < 10; i++) begin
         if (tbl[i].idle) begin
            chk($sformatf("v%0d_idle", i), v1, 0);
            r1 = tbl[i].req;
            exp_q.push_back(tbl[i].exp_idx);
         end
         waited = 0;
         while (!v1 && waited < 20) begin
            step();
            waited++;
         end
         chk($sformatf("v%0d_lat", i), waited, tbl[i].lat);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         chk($sformatf("v%0d_idx", i), i1, e);
         chk($sformatf("v%0d_oh", i), g1, 1 << e);
         chk($sformatf("v%0d_valid", i), v1, 1);
         if (tbl[i].pulse) r1 = '0;
         last = (tbl[i].aw_c > tbl[i].w_c) ? tbl[i].aw_c
                                           : tbl[i].w_c;
         for (int c = 0; c <= last; c++) begin
            awv1 = (c == tbl[i].aw_c);
            wv1  = (c == tbl[i].w_c);
            bv1  = tbl[i].binj;
            bb1  = tbl[i].binj;
            step();
            chk($sformatf("v%0d_hold_ad", i), g1, 1 << e);
         end
         awv1 = 0; wv1 = 0; bv1 = 0; bb1 = 0;
         for (int s = 0; s < tbl[i].b_st; s++) begin
            step();
            chk($sformatf("v%0d_hold_b", i), g1, 1 << e);
         end
         bv1 = 1; bb1 = 1;
         r1 = '0;
         if (i < 9) begin
            if (!tbl[i+1].idle) begin
               r1 = tbl[i+1].req;
               exp_q.push_back(tbl[i+1].exp_idx);
            end
         end
         step();
         bv1 = 0; bb1 = 0;
      end

      // Reset in RESP drops the grant; pointer restarts at 0.
      chk("end_idle", v1, 0);
      r1 = 4'b0100;
      step();
      chk("pre_rst_g", g1, 4);
      r1 = 4'b0000;
      awv1 = 1; wv1 = 1;
      step();
      awv1 = 0; wv1 = 0;
      aresetn = 1'b0;
      r1 = 4'b1111;
      step();
      chk("rst_mid_g", g1, 0);
      chk("rst_mid_i", i1, 0);
      chk("rst_mid_v", v1, 0);
      step();
      chk("rst_hold_v", v1, 0);
      aresetn = 1'b1;
      step();
      chk("rst_regrant_g", g1, 1);
      chk("rst_regrant_i", i1, 0);
      awv1 = 1; wv1 = 1;
      step();
      awv1 = 0; wv1 = 0;
      r1 = '0; bv1 = 1; bb1 = 1;
      step();
      bv1 = 0; bb1 = 0;
      chk("final_idle", v1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axil_arbiter_wr.md
Name: axil_arbiter_wr

Overview:
Parametrised write-channel arbiter for the AXI-Lite interconnect. It replaces the fixed-priority-only write arbiter with these capabilities:
- selectable fixed-priority or round-robin arbitration;
- tracking of the AW, W and B handshakes of the granted master;
- back-to-back grant hand-over with no idle bubble.

It sits between the master-side request decode and the write-path muxes. It drives the one-hot grant and encoded grant index that steer AW/W/B.

Parameters:
NUMBER_MASTER, 2, number of competing masters; legal range 1..16.
ARB_MODE, 1, 0 = fixed priority (index 0 highest); 1 = round-robin.
IDX_W, (NUMBER_MASTER>1 ? $clog2(NUMBER_MASTER) : 1), width of the grant index; derived, not overridden.

Ports:
aclk  in  1  clock.
aresetn  in  1  synchronous active-low reset.
request_wr  in  NUMBER_MASTER  per-master write request (master awvalid).
grant_wr  out  NUMBER_MASTER  one-hot grant, registered.
grant_wr_idx  out  IDX_W  encoded index of grant_wr, registered.
grant_valid  out  1  high while any grant is held (equals |grant_wr).
mux_awvalid  in  1  muxed AW valid, granted master to slave.
mux_awready  in  1  muxed AW ready from slave.
mux_wvalid  in  1  muxed W valid.
mux_wready  in  1  muxed W ready.
mux_bvalid  in  1  B valid from slave.
mux_bready  in  1  muxed B ready from the granted master.

Behaviour:
- Reset (aresetn=0 at posedge aclk): state IDLE, grant_wr=0, grant_wr_idx=0, grant_valid=0, aw_done=0, w_done=0, rr_ptr=0. Reset mid-transaction drops the grant immediately; the transaction is not completed.
- States: IDLE, ADDR_DATA, RESP.
- IDLE: if |request_wr, then at the next edge load grant_wr/grant_wr_idx with the winner and go to ADDR_DATA. Latency is request sampled at cycle N, grant visible at N+1.
- Winner selection:
  - ARB_MODE=0: lowest set index.
  - ARB_MODE=1: first set index searching upward from rr_ptr with wrap-around modulo NUMBER_MASTER.
- ADDR_DATA:
  - aw_done sets on mux_awvalid&mux_awready; w_done sets on mux_wvalid&mux_wready.
  - AW and W may complete in either order or in the same cycle.
  - When both are done (registered or current-cycle handshake), go to RESP and clear aw_done/w_done at that edge.
- RESP: wait for mux_bvalid&mux_bready. On that handshake:
  - rr_ptr <= (grant_wr_idx+1) mod NUMBER_MASTER, updated in both modes but used only in mode 1;
  - if |request_wr, re-arbitrate in the same cycle using the updated pointer value and go to ADDR_DATA with the new grant (zero-bubble hand-over);
  - otherwise clear grant_wr/grant_wr_idx and go to IDLE.
- The grant never changes outside the IDLE->ADDR_DATA and RESP->ADDR_DATA/IDLE transitions. request_wr deasserting while granted is ignored.
- bvalid seen in ADDR_DATA is ignored (protocol violation; no state change).
- NUMBER_MASTER=1: grant_wr_idx is constantly 0 and rr_ptr stays 0.
- Fairness, mode 1: with all requests held high, grants rotate 0,1,...,N-1,0. No master waits more than N-1 transactions.
- grant_wr is always one-hot or zero, and grant_wr_idx is consistent with it.

Decomposition:
- Package axil_arb_pkg:
  - enum arb_state_e {IDLE, ADDR_DATA, RESP};
  - constants ARB_FIXED=0 and ARB_RR=1;
  - function idx_w(n).
- Sub-module axil_arb_pick: combinational. Inputs: request vector, start pointer, mode. Outputs: one-hot winner, index, any flag. Implemented as a double-width rotate-and-priority-encode. Shared with the future read arbiter.

Test Plan:
- Mode 0, request_wr=2'b11 held: grant_wr=01 at cycle+1; AW and W same cycle, B two cycles later; next edge grant_wr=01 again (master 0 re-wins).
- Mode 1, N=4, request_wr=4'b1111 held, four full transactions: grant_wr_idx sequence 0,1,2,3, then 0; zero idle cycles between grants.
- W handshake 3 cycles before AW: state stays ADDR_DATA until AW, then RESP. The grant holds through an 8-cycle bvalid stall.
- Mode 1, rr_ptr=3, request_wr=4'b0101: wrap-around search grants index 0; after completion rr_ptr=1, and with request_wr=4'b0101 still set, index 2 wins.
- aresetn low in RESP with grant_wr=0100: next edge all outputs 0, state IDLE. Requests held through reset are re-granted one cycle after release, starting from rr_ptr=0.
- Request pulse of 1 cycle on master 1 in IDLE: grant_wr=10 at next edge and held until the B handshake even though request_wr drops.
